// File: rtl/mem_responder.sv
// Multicycle single-port memory model answering one-cycle mem_read/mem_write pulses.
// Optional completion counters are enabled by defining MEM_ACCESS_COUNT_EN.
module mem_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [15:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    op;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              cnt;
  logic                    accept;
  logic                    complete;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // Address bits above ADDR_WIDTH alias onto the low window.
  if (ADDR_WIDTH < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[15:ADDR_WIDTH];
  end

  always_comb begin
    accept   = (state == IDLE) && (mem_write || mem_read);
    complete = (state == ACCESS) && (cnt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the state register, so no input reaches these combinationally.
  always_comb begin
    ready = (state == RESP);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op       <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      if (accept) begin
        op     <= mem_write;
        addr_q <= address[ADDR_WIDTH-1:0];
        cnt    <= CNT_INIT;
        if (mem_write) wdata_q <= data_in;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && !op) data_out <= mem[addr_q];
    end
  end

  // Storage is never cleared; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (reset_n && complete && op) mem[addr_q] <= wdata_q;
  end

`ifdef MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (complete) begin
      if (op  && wr_count != '1) wr_count <= wr_count + 16'd1;
      if (!op && rd_count != '1) rd_count <= rd_count + 16'd1;
    end
  end
`else
  always_comb begin
    rd_count = '0;
    wr_count = '0;
  end
`endif

endmodule
